vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 29 ++
 rtl/vga_timing.sv | 158 +++++++++++++++
 tb/tb_vga_timing.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Groups the timing outputs of vga_timing into one bundle.
//   pix_en      one-clk pulse per pixel slot
//   x, y        current pixel / line counters (10 bits each)
//   hsync       horizontal sync, active-low, pipeline aligned
//   vsync       vertical sync, active-low, pipeline aligned
//   blank_n     high inside the visible area, pipeline aligned
//   frame_start one-clk pulse when the counters wrap to (0,0)
// master: the timing generator drives the bundle.
// slave : a downstream pixel/RGB stage consumes it.
// ---------------------------------------------------------------------------
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       frame_start;

    modport master (
        output pix_en, x, y, hsync, vsync, blank_n, frame_start
    );

    modport slave (
        input pix_en, x, y, hsync, vsync, blank_n, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running VGA raster timing generator. A clock divider produces one
// pix_en pulse every CLK_DIV clk cycles; on each pulse the x/y counters
// advance through an H_TOTAL x V_TOTAL raster. Sync and blank are decoded
// from x/y and delayed by PIPE_DELAY clk cycles so they line up with a
// registered RGB stage downstream.
//
// Ports
//   clk    input   system clock (single clock domain)
//   rst_n  input   asynchronous active-low reset
//   vga    master  timing bundle (pix_en, x, y, hsync, vsync, blank_n,
//                  frame_start)
//
// Parameters
//   HRES/VRES                 visible pixels / lines
//   H_FP/H_SYNC/H_BP          horizontal porch and sync widths (pixels)
//   V_FP/V_SYNC/V_BP          vertical porch and sync widths (lines)
//   CLK_DIV                   clk cycles per pixel, 1..16
//   PIPE_DELAY                clk delay on hsync/vsync/blank_n, 0..7
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int HRES       = 640,
    parameter int VRES       = 480,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

    // All compare constants are pre-sized to the counter width.
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(HRES);
    localparam logic [9:0] V_VIS    = 10'(VRES);
    localparam logic [9:0] HS_START = 10'(HRES + H_FP);
    localparam logic [9:0] HS_END   = 10'(HRES + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(VRES + V_FP);
    localparam logic [9:0] VS_END   = 10'(VRES + V_FP + V_SYNC);
    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;
    logic       pix_en_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       frame_start_q;
    logic       hs_raw;
    logic       vs_raw;
    logic       bl_raw;
    logic       hsync_d;
    logic       vsync_d;
    logic       blank_d;

    // Pixel-rate divider. pix_en is registered from the terminal count, so
    // the first pulse appears CLK_DIV edges after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= 4'd0;
            pix_en_q <= 1'b0;
        end else begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= 4'd0;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
            pix_en_q <= (div_cnt == DIV_MAX);
        end
    end

    // Raster counters. frame_start is raised on the same edge that wraps
    // (H_MAX, V_MAX) to (0,0), so it is high exactly while the counters
    // first read (0,0); the reset-time (0,0) never produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (pix_en_q) begin
                if (x_q == H_MAX) begin
                    x_q <= 10'd0;
                    if (y_q == V_MAX) begin
                        y_q           <= 10'd0;
                        frame_start_q <= 1'b1;
                    end else begin
                        y_q <= y_q + 10'd1;
                    end
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
        vs_raw = !((y_q >= VS_START) && (y_q < VS_END));
        bl_raw = (x_q < H_VIS) && (y_q < V_VIS);
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            // Counters reset to (0,0), which is a visible pixel, so blank
            // is gated by reset to keep blank_n low while rst_n is low.
            assign hsync_d = hs_raw;
            assign vsync_d = vs_raw;
            assign blank_d = bl_raw & rst_n;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe;
            logic [PIPE_DELAY-1:0] vs_pipe;
            logic [PIPE_DELAY-1:0] bl_pipe;

            // Stage 0 takes the raw decode; each later stage shifts by one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                    bl_pipe <= '0;
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    bl_pipe[0] <= bl_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                        bl_pipe[i] <= bl_pipe[i-1];
                    end
                end
            end

            assign hsync_d = hs_pipe[PIPE_DELAY-1];
            assign vsync_d = vs_pipe[PIPE_DELAY-1];
            assign blank_d = bl_pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign vga.pix_en      = pix_en_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_d;
    assign vga.vsync       = vsync_d;
    assign vga.blank_n     = blank_d;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Three vga_timing instances share clk and rst_n:
//   cfg[0] default 640x480 timing, CLK_DIV=2, PIPE_DELAY=1
//   cfg[1] small raster, CLK_DIV=1, PIPE_DELAY=0
//   cfg[2] small raster, CLK_DIV=4, PIPE_DELAY=3
// The small rasters let whole frames (vsync, wrap corner, frame_start)
// complete in a short run. Reset is pulsed at random points mid-frame.
// The expected outputs for each clk are derived from the number of clk
// edges seen since reset release: pixel count = (edges-1)/CLK_DIV, raster
// position = pixel count mod frame size, sync/blank from the position
// PIPE_DELAY edges earlier.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
    } out_t;

    localparam out_t RESET_OUT = '{pix_en: 1'b0, x: 10'd0, y: 10'd0,
                                   hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0};

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch reports actual vs required.
    task automatic checkOutput(input int cfg_id, input string what,
                               input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL cfg%0d %s t=%0t actual pix_en=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b fs=%0b required pix_en=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b fs=%0b",
                     cfg_id, what, $time,
                     act.pix_en, act.x, act.y, act.hs, act.vs, act.bl, act.fs,
                     exp.pix_en, exp.x, exp.y, exp.hs, exp.vs, exp.bl, exp.fs);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : cfg
            localparam int HR = (g == 0) ? 640 : (g == 1) ? 20 : 16;
            localparam int HF = (g == 0) ? 16  : (g == 1) ? 3  : 2;
            localparam int HS = (g == 0) ? 96  : (g == 1) ? 4  : 3;
            localparam int HB = (g == 0) ? 48  : (g == 1) ? 5  : 2;
            localparam int VR = (g == 0) ? 480 : (g == 1) ? 6  : 8;
            localparam int VF = (g == 0) ? 10  : (g == 1) ? 2  : 2;
            localparam int VS = (g == 0) ? 2   : (g == 1) ? 2  : 2;
            localparam int VB = (g == 0) ? 33  : (g == 1) ? 3  : 2;
            localparam int DV = (g == 0) ? 2   : (g == 1) ? 1  : 4;
            localparam int PD = (g == 0) ? 1   : (g == 1) ? 0  : 3;
            localparam int HT = HR + HF + HS + HB;
            localparam int VT = VR + VF + VS + VB;

            vga_timing_if vif();

            vga_timing #(
                .HRES(HR), .VRES(VR),
                .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .CLK_DIV(DV), .PIPE_DELAY(PD)
            ) dut (
                .clk  (clk),
                .rst_n(rst_n),
                .vga  (vif)
            );

            out_t exp_q[$];
            out_t act_now;

            assign act_now = {vif.pix_en, vif.x, vif.y, vif.hsync,
                              vif.vsync, vif.blank_n, vif.frame_start};

            // Raster position (pixels since reset, mod frame size) after
            // kk clk edges: a pixel is consumed on edges CLK_DIV+1,
            // 2*CLK_DIV+1, ...
            function automatic int pixelPos(input int kk);
                int pixels;
                pixels = (kk >= 1) ? (kk - 1) / DV : 0;
                return pixels % (HT * VT);
            endfunction

            function automatic out_t model(input int kk, input logic rst_hi);
                out_t o;
                int   pos;
                int   kd;
                int   xd;
                int   yd;
                o = RESET_OUT;
                if (rst_hi) begin
                    o.pix_en = (kk >= DV) && (kk % DV == 0);
                    pos  = pixelPos(kk);
                    o.x  = 10'(pos % HT);
                    o.y  = 10'(pos / HT);
                    o.fs = (kk - 1 >= DV) && ((kk - 1) % DV == 0) && (pos == 0);
                    kd = kk - PD;
                    if (kd >= 0) begin
                        pos  = pixelPos(kd);
                        xd   = pos % HT;
                        yd   = pos / HT;
                        o.hs = !((xd >= HR + HF) && (xd < HR + HF + HS));
                        o.vs = !((yd >= VR + VF) && (yd < VR + VF + VS));
                        o.bl = (xd < HR) && (yd < VR);
                    end
                end
                return o;
            endfunction

            // Predictor: pushes the expected outputs for this clk period.
            always @(posedge clk) begin
                #2;
                exp_q.push_back(model(edge_cnt, rst_n));
            end

            // Monitor: outputs are valid every clk; compare on the falling edge.
            always @(negedge clk) begin
                if (exp_q.size() != 0) begin
                    checkOutput(g, "outputs", act_now, exp_q.pop_front());
                end
            end

            // Reset must take effect without waiting for a clk edge.
            always @(negedge rst_n) begin
                #1;
                checkOutput(g, "async_reset", act_now, RESET_OUT);
            end
        end
    endgenerate

    // Runs 'run' clk cycles, then optionally pulses reset for 'hold' cycles.
    // rst_n only changes 1 time unit after a rising edge.
    task automatic applyStimulus(input int run, input int hold);
        repeat (run) begin
            @(posedge clk);
            #1;
            if (rst_n) edge_cnt++;
        end
        if (hold > 0) begin
            rst_n    = 1'b0;
            edge_cnt = 0;
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        $display("[TB] reset released, running");

        applyStimulus(3400, 2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(int'($urandom_range(50, 1500)), int'($urandom_range(1, 4)));
        end
        applyStimulus(3000, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
